// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: fetch stage with IF/ID register, one-entry stall hold buffer and branch squash.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   stall                         hold IF/ID and PC this cycle
//   branch_taken, branch_target   redirect request and address (low two bits ignored)
//   imem_req, imem_addr           instruction-memory request and word address
//   imem_ack, imem_rdata          request accepted, with instruction data in the same cycle
//   if_id_pc, if_id_instr         PC+4 and instruction presented to decode
//   if_id_valid                   1 = real instruction, 0 = bubble
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);
    typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, hold_pc_q, hold_pc_d, hold_instr_q, hold_instr_d;
    logic [31:0] kill_addr_q, kill_addr_d, if_id_pc_q, if_id_pc_d, if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d, req_q, req_d, ack;
    logic [31:0] pc_inc;
    // req is registered so it stays low until the first edge after reset release;
    // an ack is only meaningful while a request is actually being driven
    assign ack    = imem_ack & req_q;
    assign pc_inc = pc_q + 32'd4;
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        kill_addr_d   = kill_addr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (branch_taken) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            pc_d          = {branch_target[31:2], 2'b00};
            // an un-acked fetch must still complete, so park its address in KILL
            state_d       = (state_q == KILL || (state_q == FETCH && req_q && !ack)) ? KILL : FETCH;
            kill_addr_d   = (state_q == FETCH) ? pc_q : kill_addr_q;
        end else begin
            case (state_q)
                FETCH: begin
                    if (ack) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            hold_pc_d    = pc_inc;
                            hold_instr_d = imem_rdata;
                            state_d      = HOLD;
                        end else begin
                            if_id_pc_d    = pc_inc;
                            if_id_instr_d = imem_rdata;
                            if_id_valid_d = 1'b1;
                        end
                    end else if (!stall) begin
                        if_id_instr_d = NOP_INSTR;
                        if_id_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_pc_d    = hold_pc_q;
                        if_id_instr_d = hold_instr_q;
                        if_id_valid_d = 1'b1;
                        state_d       = FETCH;
                    end
                end
                KILL:    state_d = ack ? FETCH : KILL;
                default: state_d = FETCH;
            endcase
        end
        req_d = (state_d != HOLD);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            hold_pc_q     <= '0;
            hold_instr_q  <= '0;
            kill_addr_q   <= '0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            req_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_pc_q     <= hold_pc_d;
            hold_instr_q  <= hold_instr_d;
            kill_addr_q   <= kill_addr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            req_q         <= req_d;
        end
    end
    assign imem_req    = req_q;
    assign imem_addr   = (state_q == KILL) ? kill_addr_q : pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: randomized stimulus against a transaction-level fetch model.
module tb_instr_fetch_stage;
    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;
    logic        clk = 1'b0, rst_n, stall, branch_taken, imem_ack;
    logic [31:0] branch_target, imem_rdata, imem_addr, if_id_pc, if_id_instr;
    logic        imem_req, if_id_valid;
    logic        req2, valid2;
    logic [31:0] addr2, rdata2, pc2, instr2;
    int          n_chk = 0, n_pass = 0;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    ent_t        hq[$];
    logic [31:0] m_pc, m_addr, e_pc, e_instr;
    logic        m_req, m_discard, e_valid;
    always #5 clk = ~clk;
    assign imem_rdata = imem_addr ^ K;
    assign rdata2     = addr2 ^ K;
    instr_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
    );
    instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(32'h0), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(1'b1), .imem_rdata(rdata2), .if_id_pc(pc2),
        .if_id_instr(instr2), .if_id_valid(valid2)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask
    task automatic m_reset();
        hq.delete();
        m_pc = 0; m_addr = 0; m_req = 0; m_discard = 0;
        e_pc = 0; e_instr = NOP; e_valid = 0;
    endtask
    // One clock edge of the fetch stage described as transactions: an outstanding
    // request (possibly doomed), a queue holding at most one stalled fetch, and the
    // instruction currently presented to decode.
    task automatic m_step(input logic s, input logic b, input logic a, input logic [31:0] t);
        logic [31:0] data;
        data = m_addr ^ K;
        if (b) begin
            e_valid = 0; e_instr = NOP; hq.delete();
            m_pc = {t[31:2], 2'b00};
            if (!m_discard && m_req && !a) m_discard = 1;
            if (!m_discard) m_addr = m_pc;
            m_req = 1;
        end else if (m_discard) begin
            if (a) begin m_discard = 0; m_addr = m_pc; end
        end else if (hq.size() != 0) begin
            if (!s) begin
                e_pc = hq[0].pc; e_instr = hq[0].instr; e_valid = 1;
                hq.delete(); m_req = 1;
            end
        end else begin
            if (a) begin
                m_pc = m_addr + 32'd4;
                if (s) hq.push_back('{m_pc, data});
                else begin e_pc = m_pc; e_instr = data; e_valid = 1; end
            end else if (!s) begin
                e_instr = NOP; e_valid = 0;
            end
            m_req  = (hq.size() == 0);
            m_addr = m_pc;
        end
    endtask
    task automatic check_all(input string ph);
        chk({ph, " imem_req"}, {31'b0, imem_req}, {31'b0, m_req});
        chk({ph, " imem_addr"}, imem_addr, m_addr);
        chk({ph, " if_id_pc"}, if_id_pc, e_pc);
        chk({ph, " if_id_instr"}, if_id_instr, e_instr);
        chk({ph, " if_id_valid"}, {31'b0, if_id_valid}, {31'b0, e_valid});
    endtask
    initial begin
        rst_n = 0; stall = 0; branch_taken = 0; branch_target = 0; imem_ack = 0;
        m_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("wrap reset addr", addr2, 32'hFFFF_FFFC);
        chk("wrap reset req", {31'b0, req2}, 32'h0);
        rst_n = 1;
        m_step(stall, branch_taken, imem_ack, branch_target);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            check_all("run");
            if (i == 0) begin
                chk("wrap first req", {31'b0, req2}, 32'h1);
                chk("wrap first addr", addr2, 32'hFFFF_FFFC);
            end else if (i == 1) begin
                chk("wrap if_id_pc", pc2, 32'h0);
                chk("wrap if_id_instr", instr2, 32'h5A5A_FFFC);
                chk("wrap valid", {31'b0, valid2}, 32'h1);
                chk("wrap next addr", addr2, 32'h0);
            end else if (i == 2) begin
                chk("wrap if_id_pc2", pc2, 32'h4);
                chk("wrap addr2", addr2, 32'h4);
            end
            if (i == 300) begin
                stall = 1; branch_taken = 0; imem_ack = 0;
                #2 rst_n = 0;
                #1 m_reset();
                check_all("async reset");
                @(negedge clk);
                check_all("in reset");
                rst_n = 1;
                m_step(stall, branch_taken, imem_ack, branch_target);
            end else begin
                if (i < 20) begin
                    stall = 0; branch_taken = 0; imem_ack = m_req;
                end else begin
                    stall         = ($urandom_range(0, 3) == 0);
                    branch_taken  = ($urandom_range(0, 9) == 0);
                    imem_ack      = m_req && ($urandom_range(0, 2) != 0);
                    branch_target = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15)
                                                                 : $urandom;
                end
                m_step(stall, branch_taken, imem_ack, branch_target);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
